// File: rtl/bsg_manycore_mmio_responder_pkg.sv
// rtl/bsg_manycore_mmio_responder_pkg.sv - shared op/return encodings and field widths for the mmio responder
package bsg_manycore_mmio_responder_pkg;

  localparam int op_width_gp       = 4;
  localparam int mask_width_gp     = 4;
  localparam int reg_id_width_gp   = 5;
  localparam int ret_type_width_gp = 2;

  typedef enum logic [op_width_gp-1:0] {
    e_remote_load    = 4'd0,
    e_remote_store   = 4'd1,
    e_remote_sw      = 4'd2,
    e_remote_amoswap = 4'd3,
    e_remote_amoadd  = 4'd4
  } bsg_manycore_packet_op_e;

  typedef enum logic [ret_type_width_gp-1:0] {
    e_return_credit = 2'd0,
    e_return_int_wb = 2'd1
  } bsg_manycore_return_packet_type_e;

  // True for op codes the responder knows how to execute.
  function automatic logic op_is_known(input bsg_manycore_packet_op_e op);
    return (op == e_remote_load)    || (op == e_remote_store) ||
           (op == e_remote_sw)      || (op == e_remote_amoswap) ||
           (op == e_remote_amoadd);
  endfunction

endpackage

// File: rtl/bsg_manycore_mmio_alu.sv
// rtl/bsg_manycore_mmio_alu.sv - combinational op decoder producing write data and return payload
module bsg_manycore_mmio_alu
  import bsg_manycore_mmio_responder_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  bsg_manycore_packet_op_e          op,
  input  logic [mask_width_gp-1:0]         mask,
  input  logic [data_width_p-1:0]          old_data,
  input  logic [data_width_p-1:0]          new_data,
  output logic                             we,
  output logic [data_width_p-1:0]          next_data,
  output bsg_manycore_return_packet_type_e ret_type,
  output logic [data_width_p-1:0]          ret_data,
  output logic                             bad_op
);

  logic [data_width_p-1:0] masked_data;

  // Byte-lane merge for masked stores: lanes with a set mask bit take the new byte.
  always_comb begin
    masked_data = old_data;
    for (int i = 0; i < mask_width_gp; i++) begin
      if (mask[i]) masked_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end

  // Per-op write enable, next word and return payload; unknown ops only return a credit.
  always_comb begin
    we        = 1'b0;
    next_data = old_data;
    ret_type  = e_return_credit;
    ret_data  = '0;
    bad_op    = !op_is_known(op);
    case (op)
      e_remote_load: begin
        ret_type = e_return_int_wb;
        ret_data = old_data;
      end
      e_remote_store: begin
        we        = 1'b1;
        next_data = masked_data;
      end
      e_remote_sw: begin
        we        = 1'b1;
        next_data = new_data;
      end
      e_remote_amoswap: begin
        we        = 1'b1;
        next_data = new_data;
        ret_type  = e_return_int_wb;
        ret_data  = old_data;
      end
      e_remote_amoadd: begin
        we        = 1'b1;
        next_data = old_data + new_data;
        ret_type  = e_return_int_wb;
        ret_data  = old_data;
      end
      default: begin
        we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/bsg_manycore_mmio_responder.sv
// rtl/bsg_manycore_mmio_responder.sv - manycore endpoint executing fwd requests against a local register file
module bsg_manycore_mmio_responder
  import bsg_manycore_mmio_responder_pkg::*;
#(
  parameter  int els_p          = 16,
  parameter  int addr_width_p   = 28,
  parameter  int data_width_p   = 32,
  parameter  int x_cord_width_p = 7,
  parameter  int y_cord_width_p = 7,
  localparam int fwd_width_lp   = addr_width_p + op_width_gp + mask_width_gp + reg_id_width_gp
                                  + data_width_p + 2*(x_cord_width_p + y_cord_width_p),
  localparam int rev_width_lp   = ret_type_width_gp + reg_id_width_gp + data_width_p
                                  + x_cord_width_p + y_cord_width_p
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  input  logic [fwd_width_lp-1:0]   fwd_data_i,
  input  logic                      fwd_v_i,
  output logic                      fwd_ready_and_o,
  output logic [rev_width_lp-1:0]   rev_data_o,
  output logic                      rev_v_o,
  input  logic                      rev_ready_and_i,
  output logic                      err_o,
  output logic [15:0]               req_count_o
);

  localparam int lg_els_lp        = $clog2(els_p);
  localparam int count_width_lp   = 16;

  typedef enum logic {e_idle, e_resp} state_e;

  typedef struct packed {
    logic [addr_width_p-1:0]    addr;
    bsg_manycore_packet_op_e    op;
    logic [mask_width_gp-1:0]   mask;
    logic [reg_id_width_gp-1:0] reg_id;
    logic [data_width_p-1:0]    data;
    logic [y_cord_width_p-1:0]  src_y_cord;
    logic [x_cord_width_p-1:0]  src_x_cord;
    logic [y_cord_width_p-1:0]  y_cord;
    logic [x_cord_width_p-1:0]  x_cord;
  } fwd_pkt_s;

  typedef struct packed {
    bsg_manycore_return_packet_type_e pkt_type;
    logic [reg_id_width_gp-1:0]       reg_id;
    logic [data_width_p-1:0]          data;
    logic [y_cord_width_p-1:0]        y_cord;
    logic [x_cord_width_p-1:0]        x_cord;
  } rev_pkt_s;

  state_e                    state_r;
  rev_pkt_s                  rev_r;
  logic                      err_r;
  logic [count_width_lp-1:0] count_r;
  logic [data_width_p-1:0]   mem_r [els_p];

  fwd_pkt_s                         fwd_pkt;
  logic [lg_els_lp-1:0]             idx;
  logic                             out_of_range;
  logic                             dst_bad;
  logic                             fwd_hs;
  logic                             alu_we;
  logic [data_width_p-1:0]          alu_next;
  bsg_manycore_return_packet_type_e alu_ret_type;
  logic [data_width_p-1:0]          alu_ret_data;
  logic                             alu_bad_op;
  rev_pkt_s                         rev_next;

  assign fwd_pkt      = fwd_data_i;
  assign idx          = fwd_pkt.addr[lg_els_lp-1:0];
  assign out_of_range = |fwd_pkt.addr[addr_width_p-1:lg_els_lp];
  assign dst_bad      = (fwd_pkt.x_cord != my_x_i) || (fwd_pkt.y_cord != my_y_i);

  // Ready is forced low while reset is asserted, not just after the first clock.
  assign fwd_ready_and_o = reset_n_i && (state_r == e_idle);
  assign fwd_hs          = fwd_v_i && fwd_ready_and_o;

  bsg_manycore_mmio_alu #(
    .data_width_p(data_width_p)
  ) alu (
    .op       (fwd_pkt.op),
    .mask     (fwd_pkt.mask),
    .old_data (mem_r[idx]),
    .new_data (fwd_pkt.data),
    .we       (alu_we),
    .next_data(alu_next),
    .ret_type (alu_ret_type),
    .ret_data (alu_ret_data),
    .bad_op   (alu_bad_op)
  );

  // Return packet assembled from the request; out-of-range accesses return zero data.
  always_comb begin
    rev_next          = '0;
    rev_next.pkt_type = alu_ret_type;
    rev_next.reg_id   = fwd_pkt.reg_id;
    rev_next.data     = out_of_range ? '0 : alu_ret_data;
    rev_next.y_cord   = fwd_pkt.src_y_cord;
    rev_next.x_cord   = fwd_pkt.src_x_cord;
  end

  // Two-state request/response FSM; response, error and count all update on the accept edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      rev_r   <= '0;
      err_r   <= 1'b0;
      count_r <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if (fwd_hs) begin
            state_r <= e_resp;
            rev_r   <= rev_next;
            count_r <= count_r + 1'b1;
            err_r   <= err_r | alu_bad_op | out_of_range | dst_bad;
          end
        end
        e_resp: begin
          if (rev_ready_and_i) state_r <= e_idle;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  // Register file: written only on an accepted, in-range, writing op.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else if (fwd_hs && alu_we && !out_of_range) begin
      mem_r[idx] <= alu_next;
    end
  end

  assign rev_v_o     = (state_r == e_resp);
  assign rev_data_o  = rev_r;
  assign err_o       = err_r;
  assign req_count_o = count_r;

endmodule

// File: tb/tb_bsg_manycore_mmio_responder.sv
// tb/tb_bsg_manycore_mmio_responder.sv - randomized self-checking bench with a word-array reference model
module tb_bsg_manycore_mmio_responder;

  localparam int FW = 101;
  localparam int RW = 53;
  localparam logic [6:0] MY_X = 7'd3;
  localparam logic [6:0] MY_Y = 7'd1;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_SW = 4'd2;
  localparam logic [3:0] OP_SWAP = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [1:0] RET_CREDIT = 2'd0;
  localparam logic [1:0] RET_WB = 2'd1;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [6:0]    my_x_i = MY_X;
  logic [6:0]    my_y_i = MY_Y;
  logic [FW-1:0] fwd_data_i = '0;
  logic          fwd_v_i = 1'b0;
  logic          fwd_ready_and_o;
  logic [RW-1:0] rev_data_o;
  logic          rev_v_o;
  logic          rev_ready_and_i = 1'b0;
  logic          err_o;
  logic [15:0]   req_count_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [16];
  logic        model_err;
  logic [15:0] model_count;

  bsg_manycore_mmio_responder dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .my_x_i         (my_x_i),
    .my_y_i         (my_y_i),
    .fwd_data_i     (fwd_data_i),
    .fwd_v_i        (fwd_v_i),
    .fwd_ready_and_o(fwd_ready_and_o),
    .rev_data_o     (rev_data_o),
    .rev_v_o        (rev_v_o),
    .rev_ready_and_i(rev_ready_and_i),
    .err_o          (err_o),
    .req_count_o    (req_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
    model_err   = 1'b0;
    model_count = 16'd0;
  endtask

  function automatic logic [FW-1:0] pack_req(input logic [27:0] addr, input logic [3:0] op,
      input logic [3:0] mask, input logic [4:0] reg_id, input logic [31:0] data,
      input logic [6:0] sx, input logic [6:0] sy, input logic [6:0] dx, input logic [6:0] dy);
    return {addr, op, mask, reg_id, data, sy, sx, dy, dx};
  endfunction

  // Issue one request, check the response at N+1, optionally stall the rev link, then retire it.
  task automatic run_req(input logic [27:0] addr, input logic [3:0] op, input logic [3:0] mask,
      input logic [4:0] reg_id, input logic [31:0] data, input logic [6:0] sx, input logic [6:0] sy,
      input logic [6:0] dx, input logic [6:0] dy, input int hold);
    int          idx;
    bit          oor;
    logic [31:0] old;
    logic [1:0]  rtype;
    logic [31:0] rdata;
    logic [RW-1:0] exp_rev;
    int          w;

    idx   = int'(addr[3:0]);
    oor   = (addr[27:4] != 24'd0);
    old   = model_mem[idx];
    rtype = RET_CREDIT;
    rdata = 32'd0;
    if (oor || dx != MY_X || dy != MY_Y) model_err = 1'b1;
    case (op)
      OP_LOAD: begin
        rtype = RET_WB;
        rdata = oor ? 32'd0 : old;
      end
      OP_STORE: if (!oor) begin
        for (int b = 0; b < 4; b++)
          if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      end
      OP_SW: if (!oor) model_mem[idx] = data;
      OP_SWAP: begin
        rtype = RET_WB;
        rdata = oor ? 32'd0 : old;
        if (!oor) model_mem[idx] = data;
      end
      OP_ADD: begin
        rtype = RET_WB;
        rdata = oor ? 32'd0 : old;
        if (!oor) model_mem[idx] = old + data;
      end
      default: model_err = 1'b1;
    endcase
    model_count = model_count + 16'd1;
    exp_rev = {rtype, reg_id, rdata, sy, sx};

    @(negedge clk_i);
    fwd_data_i = pack_req(addr, op, mask, reg_id, data, sx, sy, dx, dy);
    fwd_v_i    = 1'b1;
    w = 0;
    while (!fwd_ready_and_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 20) check("fwd_ready_timeout", 64'(fwd_ready_and_o), 64'd1);
    @(posedge clk_i);
    #1;
    fwd_v_i    = 1'b0;
    fwd_data_i = {$urandom, $urandom, $urandom, $urandom};
    check("rev_v", 64'(rev_v_o), 64'd1);
    check("rev_data", 64'(rev_data_o), 64'(exp_rev));
    check("fwd_ready_in_resp", 64'(fwd_ready_and_o), 64'd0);
    check("req_count", 64'(req_count_o), 64'(model_count));
    check("err", 64'(err_o), 64'(model_err));
    for (int h = 0; h < hold; h++) begin
      fwd_v_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("stall_rev_data", 64'(rev_data_o), 64'(exp_rev));
      check("stall_rev_v", 64'(rev_v_o), 64'd1);
      check("stall_fwd_ready", 64'(fwd_ready_and_o), 64'd0);
      check("stall_req_count", 64'(req_count_o), 64'(model_count));
    end
    fwd_v_i         = 1'b0;
    rev_ready_and_i = 1'b1;
    @(posedge clk_i);
    #1;
    rev_ready_and_i = 1'b0;
    check("rev_v_retired", 64'(rev_v_o), 64'd0);
    check("fwd_ready_idle", 64'(fwd_ready_and_o), 64'd1);
  endtask

  initial begin
    logic [27:0] a;
    logic [3:0]  op;
    logic [6:0]  dx;
    model_reset();

    #13;
    check("reset_fwd_ready", 64'(fwd_ready_and_o), 64'd0);
    check("reset_rev_v", 64'(rev_v_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    check("init_fwd_ready", 64'(fwd_ready_and_o), 64'd1);
    check("init_rev_v", 64'(rev_v_o), 64'd0);
    check("init_err", 64'(err_o), 64'd0);
    check("init_req_count", 64'(req_count_o), 64'd0);

    run_req(28'd3, OP_LOAD, 4'h0, 5'd1, 32'd0, 7'd1, 7'd1, MY_X, MY_Y, 0);
    run_req(28'd5, OP_SW, 4'hF, 5'd7, 32'hCAFEF00D, 7'd2, 7'd4, MY_X, MY_Y, 0);
    run_req(28'd5, OP_LOAD, 4'h0, 5'd2, 32'd0, 7'd2, 7'd4, MY_X, MY_Y, 0);
    run_req(28'd6, OP_SW, 4'hF, 5'd3, 32'hAABBCCDD, 7'd0, 7'd0, MY_X, MY_Y, 0);
    run_req(28'd6, OP_STORE, 4'b0101, 5'd3, 32'h11223344, 7'd0, 7'd0, MY_X, MY_Y, 0);
    run_req(28'd6, OP_LOAD, 4'h0, 5'd3, 32'd0, 7'd0, 7'd0, MY_X, MY_Y, 0);
    run_req(28'd8, OP_SW, 4'hF, 5'd4, 32'hFFFFFFFF, 7'd5, 7'd6, MY_X, MY_Y, 0);
    run_req(28'd8, OP_ADD, 4'h0, 5'd4, 32'd1, 7'd5, 7'd6, MY_X, MY_Y, 0);
    run_req(28'd8, OP_SWAP, 4'h0, 5'd4, 32'd9, 7'd5, 7'd6, MY_X, MY_Y, 0);
    run_req(28'd8, OP_LOAD, 4'h0, 5'd4, 32'd0, 7'd5, 7'd6, MY_X, MY_Y, 0);
    run_req(28'd5, OP_LOAD, 4'h0, 5'd9, 32'd0, 7'd1, 7'd2, MY_X, MY_Y, 20);

    run_req(28'h15, OP_SW, 4'hF, 5'd1, 32'h12345678, 7'd1, 7'd1, MY_X, MY_Y, 0);
    run_req(28'h15, OP_LOAD, 4'h0, 5'd1, 32'd0, 7'd1, 7'd1, MY_X, MY_Y, 0);
    run_req(28'd5, OP_LOAD, 4'h0, 5'd1, 32'd0, 7'd1, 7'd1, MY_X, MY_Y, 0);
    run_req(28'd2, 4'hF, 4'hF, 5'd1, 32'h1, 7'd1, 7'd1, MY_X, MY_Y, 0);
    run_req(28'd2, OP_SW, 4'hF, 5'd1, 32'h77, 7'd1, 7'd1, 7'd9, MY_Y, 0);
    run_req(28'd2, OP_LOAD, 4'h0, 5'd1, 32'd0, 7'd1, 7'd1, MY_X, MY_Y, 0);

    for (int n = 0; n < 150; n++) begin
      a  = ($urandom_range(0, 15) == 0) ? 28'($urandom) : 28'($urandom_range(0, 15));
      op = 4'($urandom_range(0, 5));
      dx = ($urandom_range(0, 15) == 0) ? 7'($urandom) : MY_X;
      run_req(a, op, 4'($urandom), 5'($urandom), $urandom, 7'($urandom), 7'($urandom),
              dx, MY_Y, $urandom_range(0, 3));
    end

    @(negedge clk_i);
    fwd_data_i = pack_req(28'd2, OP_SW, 4'hF, 5'd1, 32'hDEADBEEF, 7'd1, 7'd1, MY_X, MY_Y);
    fwd_v_i    = 1'b1;
    @(posedge clk_i);
    #1;
    fwd_v_i = 1'b0;
    check("pre_reset_rev_v", 64'(rev_v_o), 64'd1);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    #1;
    model_reset();
    check("midresp_rev_v", 64'(rev_v_o), 64'd0);
    check("midresp_fwd_ready", 64'(fwd_ready_and_o), 64'd0);
    check("midresp_req_count", 64'(req_count_o), 64'd0);
    check("midresp_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    check("post_reset_fwd_ready", 64'(fwd_ready_and_o), 64'd1);
    for (int i = 0; i < 16; i++)
      run_req(28'(i), OP_LOAD, 4'h0, 5'(i), 32'd0, 7'd1, 7'd1, MY_X, MY_Y, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
